// File: rtl/mealy_out_buffer.sv
// Four-deep output buffer between a Mealy net and a ready-for-data consumer.
// Words are offered with an active-low dav_ pulse and a three-step handshake.
module mealy_out_buffer #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset_,
    input  logic [W-1:0] z,
    input  logic         v,
    input  logic         rfd,
    output logic [W-1:0] data,
    output logic         dav_,
    output logic         full,
    output logic         ovf
);

    typedef enum logic [1:0] {
        IDLE,
        PRESENT,
        RELEASE
    } state_t;

    state_t       state;
    state_t       state_nxt;
    logic [W-1:0] mem [0:3];
    logic [1:0]   wptr;
    logic [1:0]   rptr;
    logic [2:0]   count;
    logic         push;
    logic         pop;
    logic         load;
    logic         dav_nxt;

    assign full = (count == 3'd4);
    assign push = v && !full;

    always_comb begin
        state_nxt = state;
        dav_nxt   = dav_;
        pop       = 1'b0;
        load      = 1'b0;
        unique case (state)
            IDLE: begin
                dav_nxt = 1'b1;
                if (count != 3'd0 && rfd) begin
                    load      = 1'b1;
                    dav_nxt   = 1'b0;
                    state_nxt = PRESENT;
                end
            end
            PRESENT: begin
                dav_nxt = 1'b0;
                if (!rfd) begin
                    pop       = 1'b1;
                    dav_nxt   = 1'b1;
                    state_nxt = RELEASE;
                end
            end
            RELEASE: begin
                dav_nxt = 1'b1;
                if (rfd) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                dav_nxt   = 1'b1;
                state_nxt = IDLE;
            end
        endcase
    end

    // Storage carries no reset; validity is tracked by count and pointers.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wptr] <= z;
        end
    end

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            state <= IDLE;
            dav_  <= 1'b1;
            data  <= '0;
            wptr  <= 2'd0;
            rptr  <= 2'd0;
            count <= 3'd0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            dav_  <= dav_nxt;
            if (load) begin
                data <= mem[rptr];
            end
            if (push) begin
                wptr <= wptr + 2'd1;
            end
            if (pop) begin
                rptr <= rptr + 2'd1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
            if (v && full) begin
                ovf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mealy_out_buffer.sv
// Scoreboard bench for mealy_out_buffer: stimulus queues expected words,
// a monitor compares each word when dav_ falls.
module tb_mealy_out_buffer;

    logic       clock;
    logic       reset_;
    logic [7:0] z;
    logic       v;
    logic       rfd;
    logic [7:0] data;
    logic       dav_;
    logic       full;
    logic       ovf;

    int n_cmp = 0;
    int n_bad = 0;
    bit cons_en = 0;
    logic [7:0] expq [$];

    mealy_out_buffer #(.W(8)) dut (
        .clock (clock),
        .reset_(reset_),
        .z     (z),
        .v     (v),
        .rfd   (rfd),
        .data  (data),
        .dav_  (dav_),
        .full  (full),
        .ovf   (ovf)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_word(input logic [7:0] d, input bit queued);
        @(negedge clock);
        v = 1'b1;
        z = d;
        if (queued) expq.push_back(d);
        @(posedge clock);
        #1;
        v = 1'b0;
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while (expq.size() > 0 && t < 200) begin
            @(posedge clock);
            t++;
        end
        n_cmp++;
        if (expq.size() > 0) begin
            n_bad++;
            $display("FAIL %s: %0d words undelivered, expected 0",
                     name, expq.size());
            expq.delete();
        end
        repeat (4) @(posedge clock);
    endtask

    task automatic hold_consumer();
        @(negedge clock);
        cons_en = 0;
        rfd = 1'b0;
    endtask

    // Consumer: raise rfd while dav_ is high, drop it once a word is seen.
    initial begin
        forever begin
            @(negedge clock);
            if (cons_en) rfd = dav_;
        end
    end

    // Monitor: each falling dav_ delivers one word to compare.
    initial begin
        logic prev;
        logic [7:0] e;
        prev = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            if (prev === 1'b1 && dav_ === 1'b0) begin
                n_cmp++;
                if (expq.size() == 0) begin
                    n_bad++;
                    $display("FAIL word: got %h expected none", data);
                end else begin
                    e = expq.pop_front();
                    if (data !== e) begin
                        n_bad++;
                        $display("FAIL word: got %h expected %h", data, e);
                    end
                end
            end
            prev = dav_;
        end
    end

    initial begin
        v = 1'b0;
        z = 8'h00;
        rfd = 1'b0;
        reset_ = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_dav", {7'd0, dav_}, 8'h01);
        chk("rst_data", data, 8'h00);
        chk("rst_full", {7'd0, full}, 8'h00);
        chk("rst_ovf", {7'd0, ovf}, 8'h00);
        @(negedge clock);
        reset_ = 1'b1;

        // Single word latency
        cons_en = 1;
        repeat (2) @(posedge clock);
        push_word(8'hA5, 1);
        chk("single_k", {7'd0, dav_}, 8'h01);
        @(posedge clock);
        #1;
        chk("single_k1_dav", {7'd0, dav_}, 8'h00);
        chk("single_k1_data", data, 8'hA5);
        @(posedge clock);
        #1;
        chk("single_rel_dav", {7'd0, dav_}, 8'h01);
        drain("single");
        chk("single_full", {7'd0, full}, 8'h00);

        // Simultaneous push and pop with count==2
        hold_consumer();
        push_word(8'h20, 1);
        push_word(8'h21, 1);
        @(negedge clock);
        rfd = 1'b1;
        @(posedge clock);
        #1;
        chk("sim_present", {7'd0, dav_}, 8'h00);
        @(negedge clock);
        rfd = 1'b0;
        v = 1'b1;
        z = 8'h10;
        expq.push_back(8'h10);
        @(posedge clock);
        #1;
        v = 1'b0;
        chk("sim_release", {7'd0, dav_}, 8'h01);
        push_word(8'h30, 1);
        chk("sim_cnt3", {7'd0, full}, 8'h00);
        push_word(8'h31, 1);
        chk("sim_cnt4", {7'd0, full}, 8'h01);
        cons_en = 1;
        drain("sim");

        // Wrap-around, one word at a time
        for (int i = 0; i < 10; i++) begin
            push_word(8'h50 + 8'(i), 1);
            drain("wrap");
        end

        // Burst to full, then overflow
        hold_consumer();
        repeat (2) @(posedge clock);
        for (int i = 1; i <= 4; i++) push_word(8'(i), 1);
        chk("burst_full", {7'd0, full}, 8'h01);
        chk("burst_dav", {7'd0, dav_}, 8'h01);
        chk("burst_ovf", {7'd0, ovf}, 8'h00);
        push_word(8'hFF, 0);
        chk("ovf_set", {7'd0, ovf}, 8'h01);
        chk("ovf_full", {7'd0, full}, 8'h01);
        cons_en = 1;
        drain("burst");
        chk("ovf_sticky", {7'd0, ovf}, 8'h01);
        chk("drained_full", {7'd0, full}, 8'h00);

        // Reset in PRESENT with three words buffered
        hold_consumer();
        repeat (2) @(posedge clock);
        push_word(8'h40, 1);
        push_word(8'h41, 0);
        push_word(8'h42, 0);
        @(negedge clock);
        rfd = 1'b1;
        @(posedge clock);
        #1;
        chk("mid_present", {7'd0, dav_}, 8'h00);
        #2;
        reset_ = 1'b0;
        #1;
        chk("mid_dav", {7'd0, dav_}, 8'h01);
        chk("mid_data", data, 8'h00);
        chk("mid_full", {7'd0, full}, 8'h00);
        chk("mid_ovf", {7'd0, ovf}, 8'h00);
        @(negedge clock);
        reset_ = 1'b1;
        cons_en = 1;
        repeat (20) @(posedge clock);
        #1;
        chk("post_rst_dav", {7'd0, dav_}, 8'h01);
        chk("post_rst_q", 8'(expq.size()), 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
